// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions.
// Holds the MEM/WB controller state encoding and its default sizes.
package mips_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_wb_state_t;

endpackage

// File: rtl/mem_wb_timeout_ctr.sv
// WAIT-cycle counter for the MEM/WB controller.
// hit is raised in the counting cycle that brings the count to TIMEOUT.
module mem_wb_timeout_ctr
  import mips_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable)
      cnt <= cnt + 1'b1;
  end

  assign hit = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_controller.sv
// MEM->WB sequencer with a req/ack data-memory handshake.
// Define MEM_WB_TIMEOUT_EN to abort transactions after TIMEOUT WAIT cycles.
module mem_wb_controller
  import mips_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  mem_wb_state_t     state;
  logic              kill;
  logic              ld_q;
  logic              rw_q;
  logic [REG_AW-1:0] rd_q;

  logic mem_op;
  logic accept;
  logic tmo;

  assign mem_op = in_is_load | in_is_store;
  assign accept = in_valid & ~flush;

`ifdef MEM_WB_TIMEOUT_EN
  mem_wb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clock (clock),
    .reset (reset),
    .clear (state != WAIT),
    .enable((state == WAIT) & ~mem_ack),
    .hit   (tmo)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo = 1'b0;
`endif

  // Gated with reset so upstream is released the moment reset lands.
  assign stall = ~reset & (
    ((state == IDLE) & accept & mem_op) |
    ((state == WAIT) & ~mem_ack & ~tmo));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      kill      <= 1'b0;
      ld_q      <= 1'b0;
      rw_q      <= 1'b0;
      rd_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      mem_err   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      mem_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && mem_op) begin
            state     <= WAIT;
            kill      <= 1'b0;
            ld_q      <= in_is_load;
            rw_q      <= in_reg_write;
            rd_q      <= in_rd;
            mem_req   <= 1'b1;
            mem_we    <= in_is_store;
            mem_addr  <= in_alu_result;
            mem_wdata <= in_store_data;
          end else if (accept) begin
            wb_valid <= 1'b1;
            wb_en    <= in_reg_write;
            wb_rd    <= in_rd;
            wb_data  <= in_alu_result;
          end
        end
        WAIT: begin
          if (flush)
            kill <= 1'b1;
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!(kill || flush)) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              if (ld_q) begin
                wb_en   <= rw_q;
                wb_data <= mem_rdata;
              end
            end
          end else if (tmo) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_controller.sv
// Directed bench for mem_wb_controller.
// Timeout steps run only when MEM_WB_TIMEOUT_EN is defined.
module tb_mem_wb_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_is_load;
  logic        in_is_store;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic        flush;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_err;

  int tests = 0;
  int fails = 0;
  int stall_cnt;

  always #5 clock = ~clock;

  mem_wb_controller #(
    .DATA_W (32),
    .REG_AW (5),
    .TIMEOUT(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_is_load   (in_is_load),
    .in_is_store  (in_is_store),
    .in_reg_write (in_reg_write),
    .in_rd        (in_rd),
    .in_alu_result(in_alu_result),
    .in_store_data(in_store_data),
    .flush        (flush),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .mem_err      (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_in();
    in_valid     = 1'b0;
    in_is_load   = 1'b0;
    in_is_store  = 1'b0;
    in_reg_write = 1'b0;
    in_rd        = '0;
    in_alu_result = '0;
    in_store_data = '0;
  endtask

  task automatic drive(input logic ld, input logic st, input logic rw,
                       input logic [4:0] rd, input logic [31:0] res,
                       input logic [31:0] sd);
    in_valid      = 1'b1;
    in_is_load    = ld;
    in_is_store   = st;
    in_reg_write  = rw;
    in_rd         = rd;
    in_alu_result = res;
    in_store_data = sd;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    idle_in();
    #12;
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    @(negedge clock);
    reset = 1'b0;
    step();

    // ALU op, one cycle latency
    drive(0, 0, 1, 5'd5, 32'h1234, 0);
    #1 chk("alu_stall", 32'(stall), 0);
    step();
    idle_in();
    chk("alu_wb_valid", 32'(wb_valid), 1);
    chk("alu_wb_en", 32'(wb_en), 1);
    chk("alu_wb_rd", 32'(wb_rd), 5);
    chk("alu_wb_data", wb_data, 32'h1234);
    step();
    chk("alu_pulse_end", 32'(wb_valid), 0);
    chk("alu_data_hold", wb_data, 32'h1234);

    // Load, ack in 4th cycle of mem_req
    drive(1, 0, 1, 5'd9, 32'h40, 0);
    stall_cnt = 0;
    #1 if (stall) stall_cnt++;
    step();
    idle_in();
    chk("ld_req", 32'(mem_req), 1);
    chk("ld_we", 32'(mem_we), 0);
    chk("ld_addr", mem_addr, 32'h40);
    chk("ld_no_wb", 32'(wb_valid), 0);
    for (int i = 0; i < 3; i++) begin
      if (stall) stall_cnt++;
      step();
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1 chk("ld_ack_stall", 32'(stall), 0);
    if (stall) stall_cnt++;
    chk("ld_stall_cycles", 32'(stall_cnt), 4);
    step();
    mem_ack = 1'b0;
    mem_rdata = '0;
    chk("ld_wb_valid", 32'(wb_valid), 1);
    chk("ld_wb_en", 32'(wb_en), 1);
    chk("ld_wb_rd", 32'(wb_rd), 9);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_req_drop", 32'(mem_req), 0);

    // Store, ack in 2nd cycle of mem_req
    drive(0, 1, 1, 5'd7, 32'h80, 32'hA5A5A5A5);
    step();
    idle_in();
    for (int i = 0; i < 2; i++) begin
      chk("st_req", 32'(mem_req), 1);
      chk("st_we", 32'(mem_we), 1);
      chk("st_addr", mem_addr, 32'h80);
      chk("st_wdata", mem_wdata, 32'hA5A5A5A5);
      if (i == 1) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    chk("st_wb_valid", 32'(wb_valid), 1);
    chk("st_wb_en", 32'(wb_en), 0);
    chk("st_wb_data", wb_data, 32'hDEADBEEF);

    // Back-to-back ALU op right after retire
    drive(0, 0, 1, 5'd3, 32'h55, 0);
    #1 chk("b2b_stall", 32'(stall), 0);
    step();
    idle_in();
    chk("b2b_wb_valid", 32'(wb_valid), 1);
    chk("b2b_wb_data", wb_data, 32'h55);

    // Flush while a load is outstanding
    drive(1, 0, 1, 5'd11, 32'h44, 0);
    step();
    idle_in();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_req_held", 32'(mem_req), 1);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    chk("fl_no_wb_valid", 32'(wb_valid), 0);
    chk("fl_no_wb_en", 32'(wb_en), 0);
    chk("fl_req_drop", 32'(mem_req), 0);
    chk("fl_data_hold", wb_data, 32'h55);

    // Flush in IDLE suppresses acceptance
    drive(0, 0, 1, 5'd1, 32'h99, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_in();
    chk("fl_idle_wb", 32'(wb_valid), 0);

    // Ack in IDLE is ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ack_idle_wb", 32'(wb_valid), 0);
    chk("ack_idle_req", 32'(mem_req), 0);

    // Reset mid-WAIT
    drive(1, 0, 1, 5'd2, 32'h48, 0);
    step();
    idle_in();
    chk("rw_req_up", 32'(mem_req), 1);
    #2 reset = 1'b1;
    #1;
    chk("rw_req", 32'(mem_req), 0);
    chk("rw_stall", 32'(stall), 0);
    chk("rw_wb_data", wb_data, 0);
    @(negedge clock);
    reset = 1'b0;
    drive(0, 0, 1, 5'd4, 32'h77, 0);
    step();
    idle_in();
    chk("rw_next_valid", 32'(wb_valid), 1);
    chk("rw_next_rd", 32'(wb_rd), 4);
    chk("rw_next_data", wb_data, 32'h77);

`ifdef MEM_WB_TIMEOUT_EN
    drive(1, 0, 1, 5'd6, 32'h50, 0);
    step();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(mem_req), 1);
      if (i == 3) chk("to_stall", 32'(stall), 0);
      step();
    end
    chk("to_req_drop", 32'(mem_req), 0);
    chk("to_err", 32'(mem_err), 1);
    chk("to_no_wb", 32'(wb_valid), 0);
    step();
    chk("to_err_pulse", 32'(mem_err), 0);

    drive(1, 0, 1, 5'd8, 32'h54, 0);
    step();
    idle_in();
    for (int i = 0; i < 3; i++) step();
    mem_ack = 1'b1;
    mem_rdata = 32'h0BADC0DE;
    step();
    mem_ack = 1'b0;
    chk("to_ack_wb", 32'(wb_valid), 1);
    chk("to_ack_data", wb_data, 32'h0BADC0DE);
    chk("to_ack_err", 32'(mem_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
